line_window_gen: RTL and testbench

Streams the 6-cell sliding windows of one board line (row, column or diagonal) to the per-window stone counters in the hardware partition. It accepts one line of stone-occupancy bits per handshake and emits one 6-bit window per cycle, with position and last-window tags, so the downstream 6-input popcount can score every Connect6 window on that line. It sits between the board-line fetch logic and the window counters.

---
 rtl/line_window_gen_pkg.sv | 40 ++++
 rtl/line_window_gen.sv | 84 ++++++++
 tb/tb_line_window_gen.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/line_window_gen_pkg.sv
// ============================================================================
// Module      : line_window_gen_pkg
// Description : Shared constants, state encoding and line-kind id ranges
//               for the Connect6 line window generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package line_window_gen_pkg;

    localparam int LINE_MAX = 19;
    localparam int WIN      = 6;
    localparam int ID_W     = 7;
    localparam int POS_W    = 4;
    localparam int LEN_W    = 5;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

    // Line id allocation: 19 rows, 19 columns, 37 diagonals, 37 anti-diagonals.
    localparam int ROW_ID_FIRST  = 0;
    localparam int ROW_ID_LAST   = 18;
    localparam int COL_ID_FIRST  = 19;
    localparam int COL_ID_LAST   = 37;
    localparam int DIAG_ID_FIRST = 38;
    localparam int DIAG_ID_LAST  = 74;
    localparam int ANTI_ID_FIRST = 75;
    localparam int ANTI_ID_LAST  = 111;

    function automatic logic [LINE_MAX-1:0] len_mask(input logic [LEN_W-1:0] len);
        logic [LINE_MAX-1:0] m;
        for (int i = 0; i < LINE_MAX; i++) begin
            m[i] = (i < int'(len));
        end
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/line_window_gen.sv
// ============================================================================
// Module      : line_window_gen
// Description : Accepts one board line and streams its 6-cell sliding windows
//               with position, last and id tags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_window_gen
    import line_window_gen_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [LINE_MAX-1:0] in_line,
    input  logic [LEN_W-1:0]    in_len,
    input  logic [ID_W-1:0]     in_id,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIN-1:0]      out_window,
    output logic [POS_W-1:0]    out_pos,
    output logic                out_last,
    output logic [ID_W-1:0]     out_id
);

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [LINE_MAX-1:0] r_shift;
    logic [POS_W-1:0]    r_pos;
    logic [LEN_W-1:0]    r_last_pos;
    logic [ID_W-1:0]     r_id;
    logic [LEN_W-1:0]    w_len;
    logic                w_accept;
    logic                w_fire;
    logic                w_last;

    assign w_len    = (in_len > LEN_W'(LINE_MAX)) ? LEN_W'(LINE_MAX) : in_len;
    assign w_accept = (r_state == ST_IDLE) && in_valid;
    assign w_fire   = (r_state == ST_EMIT) && out_ready;
    // Gated by state so the idle/reset value of out_last is 0.
    assign w_last   = (r_state == ST_EMIT) && ({1'b0, r_pos} == r_last_pos);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (in_valid && (w_len >= LEN_W'(WIN))) w_state_nxt = ST_EMIT;
            ST_EMIT: if (out_ready && w_last) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_pos      <= '0;
            r_last_pos <= '0;
            r_id       <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_shift    <= in_line & len_mask(w_len);
                r_pos      <= '0;
                // Wraps for short lines; unused since those never enter EMIT.
                r_last_pos <= w_len - LEN_W'(WIN);
                r_id       <= in_id;
            end else if (w_fire && !w_last) begin
                r_shift <= {1'b0, r_shift[LINE_MAX-1:1]};
                r_pos   <= r_pos + 1'b1;
            end
        end
    end

    assign in_ready   = (r_state == ST_IDLE);
    assign out_valid  = (r_state == ST_EMIT);
    assign out_window = r_shift[WIN-1:0];
    assign out_pos    = r_pos;
    assign out_last   = w_last;
    assign out_id     = r_id;

endmodule

`default_nettype wire

// File: tb/tb_line_window_gen.sv
// ============================================================================
// Module      : tb_line_window_gen
// Description : Scoreboard bench for line_window_gen.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_line_window_gen;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [18:0] in_line;
    logic [4:0]  in_len;
    logic [6:0]  in_id;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_window;
    logic [3:0]  out_pos;
    logic        out_last;
    logic [6:0]  out_id;

    typedef struct packed {
        logic [5:0] win;
        logic [3:0] pos;
        logic       last;
        logic [6:0] id;
    } exp_t;

    exp_t q_exp[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    line_window_gen u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_line    (in_line),
        .in_len     (in_len),
        .in_id      (in_id),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_window (out_window),
        .out_pos    (out_pos),
        .out_last   (out_last),
        .out_id     (out_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_expected(input logic [18:0] line, input logic [4:0] len, input logic [6:0] id);
        int          l;
        logic [18:0] m;
        logic [18:0] sh;
        exp_t        e;
        l = (len > 5'd19) ? 19 : int'(len);
        m = line;
        for (int i = 0; i < 19; i++) if (i >= l) m[i] = 1'b0;
        for (int p = 0; p + 6 <= l; p++) begin
            sh     = m >> p;
            e.win  = sh[5:0];
            e.pos  = 4'(p);
            e.last = (p + 6 == l);
            e.id   = id;
            q_exp.push_back(e);
        end
    endtask

    // Handshakes complete at the next rising edge; sample them mid-cycle.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q_exp.size() == 0) begin
                check("unexpected_window", {31'd0, out_valid}, 32'd0);
            end else begin
                exp_t e;
                e = q_exp.pop_front();
                check("window", {26'd0, out_window}, {26'd0, e.win});
                check("pos",    {28'd0, out_pos},    {28'd0, e.pos});
                check("last",   {31'd0, out_last},   {31'd0, e.last});
                check("id",     {25'd0, out_id},     {25'd0, e.id});
            end
        end
    end

    task automatic send_line(input logic [18:0] line, input logic [4:0] len, input logic [6:0] id);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("accept_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_line  = line;
        in_len   = len;
        in_id    = id;
        push_expected(line, len, id);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_line  = 19'($urandom);
        in_len   = 5'($urandom);
        in_id    = 7'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (q_exp.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", q_exp.size(), 32'd0);
        q_exp.delete();
    endtask

    task automatic wait_pos(input logic [3:0] p);
        int n = 0;
        while (!(out_valid && out_pos == p) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("reach_pos", {28'd0, out_pos}, {28'd0, p});
    endtask

    initial begin
        logic [5:0] s_win;
        logic [3:0] s_pos;
        logic       s_last;
        logic [6:0] s_id;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_line   = '0;
        in_len    = '0;
        in_id     = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  {31'd0, in_ready},   32'd1);
        check("rst_out_valid", {31'd0, out_valid},  32'd0);
        check("rst_window",    {26'd0, out_window}, 32'd0);
        check("rst_pos",       {28'd0, out_pos},    32'd0);
        check("rst_last",      {31'd0, out_last},   32'd0);
        check("rst_id",        {25'd0, out_id},     32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Staircase full line, then in_ready high the cycle after the last window.
        send_line(19'h0003F, 5'd19, 7'h01);
        check("first_latency", {31'd0, out_valid}, 32'd1);
        drain();
        check("ready_after_line", {31'd0, in_ready}, 32'd1);

        // Masking of cells beyond in_len.
        send_line(19'h7FFFF, 5'd8, 7'h02);
        drain();
        send_line(19'h7FFFF, 5'd7, 7'h03);
        drain();

        // Boundary lengths.
        send_line(19'h0002A, 5'd6, 7'h04);
        drain();
        send_line(19'h7FFFF, 5'd5, 7'h05);
        check("short_no_valid", {31'd0, out_valid}, 32'd0);
        check("short_ready",    {31'd0, in_ready},  32'd1);
        send_line(19'h7FFFF, 5'd0, 7'h06);
        send_line(19'h7FFFF, 5'd3, 7'h07);
        send_line(19'h7FFFF, 5'd5, 7'h08);
        repeat (3) begin
            check("b2b_no_valid", {31'd0, out_valid}, 32'd0);
            @(posedge clk); #1;
        end

        // Over-length in_len is clamped to a full line.
        send_line(19'h7FFFF, 5'd25, 7'h09);
        drain();

        // Backpressure at pos 3.
        send_line(19'h5A3C7, 5'd19, 7'h45);
        wait_pos(4'd3);
        out_ready = 1'b0;
        s_win  = out_window;
        s_pos  = out_pos;
        s_last = out_last;
        s_id   = out_id;
        repeat (4) begin
            @(negedge clk);
            check("stall_valid",  {31'd0, out_valid},  32'd1);
            check("stall_window", {26'd0, out_window}, {26'd0, s_win});
            check("stall_pos",    {28'd0, out_pos},    {28'd0, s_pos});
            check("stall_last",   {31'd0, out_last},   {31'd0, s_last});
            check("stall_id",     {25'd0, out_id},     {25'd0, s_id});
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();

        // Asynchronous reset mid-line.
        send_line(19'h3C3C3, 5'd19, 7'h33);
        wait_pos(4'd7);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_in_ready",  {31'd0, in_ready},   32'd1);
        check("arst_out_valid", {31'd0, out_valid},  32'd0);
        check("arst_window",    {26'd0, out_window}, 32'd0);
        check("arst_pos",       {28'd0, out_pos},    32'd0);
        check("arst_last",      {31'd0, out_last},   32'd0);
        check("arst_id",        {25'd0, out_id},     32'd0);
        q_exp.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_line(19'h00F0F, 5'd19, 7'h12);
        check("post_rst_valid", {31'd0, out_valid}, 32'd1);
        check("post_rst_pos",   {28'd0, out_pos},   32'd0);
        check("post_rst_id",    {25'd0, out_id},    32'h12);
        drain();

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
